serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Parallel-to-serial feeder that produces the single-bit stream `x` consumed by the sequence-detector FSMs of this guide. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, with a qualifying `x_valid`. It drives an idle level between words so that gaps are not mistaken for data zeros. It supports gapless back-to-back streaming.

## Interface
- `WIDTH`, 8: bits per word; must be at least 2.
- `MSB_FIRST`, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `IDLE_BIT`, 1: level driven on `x` while no word is being shifted.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a word to send.
- `in_data`  in  WIDTH  word to serialize; sampled only on acceptance.
- `in_ready`  out  1  the block can accept a word this cycle (combinational from state).
- `x`  out  1  serial data bit (registered).
- `x_valid`  out  1  `x` carries a data bit this cycle (registered).
- `done`  out  1  one-cycle pulse coincident with the last bit of a word (registered).
- `busy`  out  1  a word is being shifted (equals `x_valid`).

## Operation
- Reset is synchronous, active-high and has priority over everything else.
- Values after the reset edge:
  - state = IDLE, `x` = IDLE_BIT, `x_valid` = 0, `done` = 0, `busy` = 0.
  - shift register and bit counter = 0.
  - `in_ready` = 1.
- State machine:
  - IDLE:
    - `in_ready` = 1.
    - On `in_valid` && `in_ready`, load `in_data` into the shift register and clear the bit counter.
    - Drive the first bit on `x` and set `x_valid` = 1.
    - Go to SHIFT.
    - Otherwise hold `x` = IDLE_BIT and `x_valid` = 0.
  - SHIFT:
    - Each edge advances one bit and increments the counter.
    - `in_ready` = 1 only while the current bit is the last one (counter = WIDTH-1).
    - At the last bit with a handshake: load the new word and output its first bit on the next cycle, with no idle gap. Stay in SHIFT.
    - At the last bit without a handshake: go to IDLE. `x` returns to IDLE_BIT and `x_valid` to 0.
- Bit order:
  - MSB_FIRST = 1: output order is in_data[WIDTH-1] down to in_data[0].
  - MSB_FIRST = 0: output order is in_data[0] up to in_data[WIDTH-1].
- `done` = 1 exactly in the cycle where `x` carries the last bit of a word.
- The counter width is clog2(WIDTH). It wraps to 0 on each new load and never exceeds WIDTH-1.
- While `in_ready` = 0, `in_valid` and `in_data` are ignored. A held `in_valid` is accepted at the first cycle where `in_ready` = 1. The word is not lost and not duplicated.
- Reset while in SHIFT:
  - The current word is aborted and discarded.
  - The next cycle shows idle outputs.
  - No `done` pulse is generated for the aborted word.
- Reset asserted together with `in_valid` does not cause an acceptance.

## Timing
- Acceptance at edge k: first bit valid on `x` during cycle k+1, through edge k+1.
- Last bit on `x` during cycle k+WIDTH, with `done` = 1 in that cycle.
- Latency from handshake to first bit: 1 cycle. Occupancy: WIDTH cycles per word.
- Back-to-back words: sustained throughput of 1 bit per cycle, with zero idle cycles between words.
- Isolated word: from cycle k+WIDTH+1 `x` = IDLE_BIT and `x_valid` = 0, until the next acceptance.
- `x`, `x_valid` and `done` change only at rising edges. The downstream FSM samples `x` on the same edge stream.

## Test plan
- **Reset values:** hold `reset` for 2 cycles, then release with `in_valid` = 0. Required: `x` = 1, `x_valid` = 0, `done` = 0, `in_ready` = 1 for 5 cycles.
- **Single word, MSB first:** WIDTH = 8, word 8'b1000_0001 accepted at edge k. Required: `x` over cycles k+1..k+8 = 1,0,0,0,0,0,0,1; `x_valid` = 1 over those cycles; `done` only at k+8; idle from k+9.
- **Back-to-back:** words 8'hF0 then 8'h0F, with `in_valid` held.
  - Second word accepted at edge k+8 (`in_ready` = 1 only in cycle k+8).
  - `x` over 16 consecutive cycles = 1111000000001111.
  - `x_valid` stays 1 throughout; `done` pulses at k+8 and k+16.
  - Feeding this `x` to the x000 detector yields its match indication.
- **Busy stall:** assert `in_valid` with 8'hAA during bit 3 of word 8'h55. Required:
  - `in_ready` = 0 until the last bit of 8'h55.
  - 8'h55 completes unaltered.
  - 8'hAA follows immediately and is sent exactly once.
- **Reset mid-word:** assert `reset` during bit 4 of 8'hC3. Required:
  - Next cycle `x` = 1 and `x_valid` = 0.
  - No `done` pulse for 8'hC3.
  - A following word 8'h81 is serialized correctly from bit 7.
- **LSB first:** WIDTH = 4, MSB_FIRST = 0, IDLE_BIT = 0, word 4'b0011. Required: `x` = 1,1,0,0 over 4 cycles; `done` on the 4th; then `x` = 0 with `x_valid` = 0.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words over valid/ready and
// emits them one bit per clock on x, qualified by x_valid, with no gap between words.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             x_reg, x_next;
  logic             x_valid_reg, x_valid_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] in_ord;
  logic             at_last;
  logic             load;

  // Reorder the input so the shifter always emits from its top bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign in_ord[gi] = in_data[gi];
      end else begin : g_lsb
        assign in_ord[gi] = in_data[WIDTH-1-gi];
      end
    end
  endgenerate

  assign at_last  = (state_reg == SHIFT) && (cnt_reg == LAST);
  assign in_ready = (state_reg == IDLE) || at_last;
  assign load     = in_valid && in_ready;

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    cnt_next     = cnt_reg;
    x_next       = x_reg;
    x_valid_next = x_valid_reg;
    if (load) begin
      // The first bit goes straight to x; the register keeps the rest.
      state_next   = SHIFT;
      shreg_next   = {in_ord[WIDTH-2:0], 1'b0};
      cnt_next     = '0;
      x_next       = in_ord[WIDTH-1];
      x_valid_next = 1'b1;
    end else if (state_reg == SHIFT) begin
      if (at_last) begin
        state_next   = IDLE;
        cnt_next     = '0;
        x_next       = IDLE_BIT;
        x_valid_next = 1'b0;
      end else begin
        shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
        cnt_next   = cnt_reg + CW'(1);
        x_next     = shreg_reg[WIDTH-1];
      end
    end else begin
      x_next       = IDLE_BIT;
      x_valid_next = 1'b0;
    end
    done_next = x_valid_next && (cnt_next == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      cnt_reg     <= '0;
      x_reg       <= IDLE_BIT;
      x_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      cnt_reg     <= cnt_next;
      x_reg       <= x_next;
      x_valid_reg <= x_valid_next;
      done_reg    <= done_next;
    end
  end

  assign x       = x_reg;
  assign x_valid = x_valid_reg;
  assign done    = done_reg;
  assign busy    = x_valid_reg;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: an 8-bit MSB-first instance and a
// 4-bit LSB-first instance with idle level 0.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, x, x_valid, done, busy;
  logic [7:0] in_data;
  logic       in_valid4, in_ready4, x4, x_valid4, done4, busy4;
  logic [3:0] in_data4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .x(x), .x_valid(x_valid), .done(done), .busy(busy)
  );

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .x(x4), .x_valid(x_valid4), .done(done4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle8(input string tag);
    chk({tag, " x"}, x, 1'b1);
    chk({tag, " x_valid"}, x_valid, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " in_ready"}, in_ready, 1'b1);
  endtask

  task automatic bit8(input string tag, input int i, input logic ex, input logic ed);
    chk($sformatf("%s x[%0d]", tag, i), x, ex);
    chk($sformatf("%s x_valid[%0d]", tag, i), x_valid, 1'b1);
    chk($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
    chk($sformatf("%s done[%0d]", tag, i), done, ed);
  endtask

  task automatic one_word(input string tag, input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit8(tag, i, w[7-i], i == 7);
      chk($sformatf("%s in_ready[%0d]", tag, i), in_ready, i == 7);
      step();
    end
    idle8({tag, " idle"});
  endtask

  task automatic two_words(input string tag, input logic [7:0] w1, input logic [7:0] w2,
                           input int raise_at);
    logic [15:0] exp_bits;
    exp_bits = {w1, w2};
    in_valid = 1'b1;
    in_data  = w1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == raise_at) begin
        in_valid = 1'b1;
        in_data  = w2;
      end
      if (i == 8) in_valid = 1'b0;
      bit8(tag, i, exp_bits[15-i], (i == 7) || (i == 15));
      chk($sformatf("%s in_ready[%0d]", tag, i), in_ready, (i == 7) || (i == 15));
      step();
    end
    idle8({tag, " idle"});
  endtask

  initial begin
    logic [15:0] stream;
    logic [3:0]  w4;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid4 = 1'b0;
    in_data4  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle8($sformatf("reset c%0d", i));
      chk("reset x4", x4, 1'b0);
      chk("reset x_valid4", x_valid4, 1'b0);
      chk("reset in_ready4", in_ready4, 1'b1);
      step();
    end

    one_word("single81", 8'h81);

    // Spot-check the documented back-to-back pattern before the generic run.
    stream = {8'hF0, 8'h0F};
    chk("b2b pattern", stream[15], 1'b1);
    two_words("b2b", 8'hF0, 8'h0F, 0);

    two_words("stall", 8'h55, 8'hAA, 3);

    // Abort 8'hC3 at bit 4, with in_valid also raised during reset.
    in_valid = 1'b1;
    in_data  = 8'hC3;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit8("abortC3", i, stream[0] ^ stream[0] ^ 8'hC3 >> (7 - i), 1'b0);
      if (i < 4) step();
    end
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h81;
    step();
    idle8("abort reset");
    reset = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit8("after81", i, (i == 0) || (i == 7), i == 7);
      step();
    end
    idle8("after81 idle");
    chk("after81 no dup x_valid", x_valid, 1'b0);

    // LSB-first, 4-bit, idle level 0.
    w4        = 4'b0011;
    in_valid4 = 1'b1;
    in_data4  = w4;
    step();
    in_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lsb x4[%0d]", i), x4, i < 2);
      chk($sformatf("lsb x_valid4[%0d]", i), x_valid4, 1'b1);
      chk($sformatf("lsb busy4[%0d]", i), busy4, 1'b1);
      chk($sformatf("lsb done4[%0d]", i), done4, i == 3);
      chk($sformatf("lsb in_ready4[%0d]", i), in_ready4, i == 3);
      step();
    end
    chk("lsb idle x4", x4, 1'b0);
    chk("lsb idle x_valid4", x_valid4, 1'b0);
    chk("lsb idle done4", done4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
